// File: rtl/prog_loader.sv
// prog_loader: boot-time instruction loader.
// Accepts a valid/ready word stream and writes consecutive words into
// instruction memory starting at BASE_ADDR. The CPU is held in reset until
// the image is complete, then released after SETTLE_CYCLES.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When it is defined, the
// s_last word is a checksum of the image and is not written to memory.
module prog_loader #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DAT_WIDTH     = 32,
  parameter int                    DEPTH_WORDS   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    SETTLE_CYCLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           s_valid,
  input  logic [DAT_WIDTH-1:0]           s_data,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic                           imem_we,
  output logic [ADDR_WIDTH-1:0]          imem_addr,
  output logic [DAT_WIDTH-1:0]           imem_wdata,
  output logic                           cpu_rst_n,
  output logic [$clog2(DEPTH_WORDS):0]   word_cnt_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int CW = $clog2(DEPTH_WORDS) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    ERR
  } state_t;

  state_t                 state;
  logic [CW-1:0]          idx;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic [SW-1:0]          settle_cnt;
  logic                   accept;
  logic                   full;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DAT_WIDTH-1:0]   sum;
`endif

  // Stream handshake and "memory already holds DEPTH_WORDS accepted words"
  always_comb begin
    accept = s_valid && s_ready;
    full   = (idx == CW'(DEPTH_WORDS));
  end

  // Load sequencer: state, registered memory write port and CPU reset control
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      word_cnt_o <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      idx        <= '0;
      next_addr  <= BASE_ADDR;
      settle_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start_i) begin
            state      <= LOAD;
            s_ready    <= 1'b1;
            idx        <= '0;
            word_cnt_o <= '0;
            next_addr  <= BASE_ADDR;
            err_o      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end

        LOAD: begin
          if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            // The checksum word never occupies memory, so it is legal even
            // when the memory is already full.
            if (s_last) begin
              s_ready    <= 1'b0;
              settle_cnt <= '0;
              if (s_data == sum) begin
                state <= SETTLE;
              end else begin
                state <= ERR;
                err_o <= 1'b1;
              end
            end else if (full) begin
              s_ready <= 1'b0;
              err_o   <= 1'b1;
              state   <= ERR;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= next_addr;
              imem_wdata <= s_data;
              next_addr  <= next_addr + ADDR_WIDTH'(4);
              idx        <= idx + CW'(1);
              word_cnt_o <= idx + CW'(1);
              sum        <= sum + s_data;
            end
`else
            if (full) begin
              s_ready <= 1'b0;
              err_o   <= 1'b1;
              state   <= ERR;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= next_addr;
              imem_wdata <= s_data;
              next_addr  <= next_addr + ADDR_WIDTH'(4);
              idx        <= idx + CW'(1);
              word_cnt_o <= idx + CW'(1);
              if (s_last) begin
                state      <= SETTLE;
                s_ready    <= 1'b0;
                settle_cnt <= '0;
              end
            end
`endif
          end
        end

        SETTLE: begin
          // The first edge in SETTLE closes the final write cycle; the next
          // SETTLE_CYCLES edges form the settle window.
          if (settle_cnt == SW'(SETTLE_CYCLES)) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            done_o    <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        RUN: begin
          state <= RUN;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed testbench for prog_loader.
// Uses DEPTH_WORDS=4 so the overflow case fits a short image; the 3-word
// images of the other cases fit in the same instance.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic [2:0]  word_cnt_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];

  prog_loader #(
    .ADDR_WIDTH(32),
    .DAT_WIDTH(32),
    .DEPTH_WORDS(4),
    .BASE_ADDR(32'h0),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n),
    .word_cnt_o(word_cnt_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Edge counter used to measure release latency
  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      addr_q.push_back(imem_addr);
      data_q.push_back(imem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    addr_q.delete();
    data_q.delete();
  endtask

  task automatic pulseStart();
    start_i = 1'b1;
    stepCycle();
    start_i = 1'b0;
  endtask

  // Offer one word and wait (bounded) for its handshake, then idle gap cycles
  task automatic applyStimulus(input logic [31:0] data, input logic last, input int gap);
    logic rdy;
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = data;
    s_last = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = s_ready;
      stepCycle();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    hs_cyc = cyc;
    if (!ok) checkOutput("handshake_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
    s_last = 1'b0;
    for (int g = 0; g < gap; g++) stepCycle();
  endtask

  // Wait (bounded) for cpu_rst_n to rise and check distance from last handshake
  task automatic waitRelease(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      stepCycle();
      if (cpu_rst_n === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_released"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_latency"}, cyc - hs_cyc, 32'd5);
  endtask

  task automatic checkWrites(input string tag, input int n, input logic [31:0] exp_data[5]);
    checkOutput({tag, "_wcount"}, addr_q.size(), n);
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), addr_q[i], 32'(i * 4));
      checkOutput($sformatf("%s_data%0d", tag, i), data_q[i], exp_data[i]);
    end
  endtask

  logic [31:0] img[5];

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;

    doReset();
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("rst_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'h0);
    checkOutput("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("rst_word_cnt", {29'd0, word_cnt_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum match: 1 + 2 = 3
    img = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h0};
    pulseStart();
    applyStimulus(32'h1, 1'b0, 0);
    applyStimulus(32'h2, 1'b0, 0);
    applyStimulus(32'h3, 1'b1, 0);
    waitRelease("ck_ok");
    checkOutput("ck_ok_done", {31'd0, done_o}, 32'd1);
    checkOutput("ck_ok_err", {31'd0, err_o}, 32'd0);
    checkOutput("ck_ok_word_cnt", {29'd0, word_cnt_o}, 32'd2);
    checkWrites("ck_ok", 2, img);

    // Checksum mismatch: 4 != 3
    doReset();
    pulseStart();
    applyStimulus(32'h1, 1'b0, 0);
    applyStimulus(32'h2, 1'b0, 0);
    applyStimulus(32'h4, 1'b1, 0);
    for (int i = 0; i < 8; i++) stepCycle();
    checkOutput("ck_bad_err", {31'd0, err_o}, 32'd1);
    checkOutput("ck_bad_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("ck_bad_done", {31'd0, done_o}, 32'd0);
    checkOutput("ck_bad_s_ready", {31'd0, s_ready}, 32'd0);
    checkWrites("ck_bad", 2, img);
`else
    // Continuous 3-word image
    img = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0, 32'h0};
    pulseStart();
    checkOutput("load_s_ready", {31'd0, s_ready}, 32'd1);
    applyStimulus(img[0], 1'b0, 0);
    applyStimulus(img[1], 1'b0, 0);
    applyStimulus(img[2], 1'b1, 0);
    checkOutput("cont_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
    waitRelease("cont");
    checkOutput("cont_done", {31'd0, done_o}, 32'd1);
    checkOutput("cont_err", {31'd0, err_o}, 32'd0);
    checkOutput("cont_word_cnt", {29'd0, word_cnt_o}, 32'd3);
    checkWrites("cont", 3, img);

    // RUN ignores start_i and the stream
    start_i = 1'b1;
    s_valid = 1'b1;
    s_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) stepCycle();
    start_i = 1'b0;
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("run_wcount", addr_q.size(), 32'd3);
    checkOutput("run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
    checkOutput("run_done", {31'd0, done_o}, 32'd1);
    checkOutput("run_s_ready", {31'd0, s_ready}, 32'd0);

    // Same image with a one-cycle gap after every word
    doReset();
    pulseStart();
    applyStimulus(img[0], 1'b0, 1);
    applyStimulus(img[1], 1'b0, 1);
    applyStimulus(img[2], 1'b1, 0);
    waitRelease("gap");
    checkOutput("gap_word_cnt", {29'd0, word_cnt_o}, 32'd3);
    checkWrites("gap", 3, img);

    // Overflow: 5 words into a 4-word memory
    img = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    doReset();
    pulseStart();
    for (int i = 0; i < 5; i++) applyStimulus(img[i], (i == 4), 0);
    for (int i = 0; i < 8; i++) stepCycle();
    checkWrites("ovf", 4, img);
    checkOutput("ovf_err", {31'd0, err_o}, 32'd1);
    checkOutput("ovf_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("ovf_done", {31'd0, done_o}, 32'd0);
    checkOutput("ovf_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("ovf_word_cnt", {29'd0, word_cnt_o}, 32'd4);
    pulseStart();
    checkOutput("restart_err", {31'd0, err_o}, 32'd0);
    checkOutput("restart_s_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("restart_word_cnt", {29'd0, word_cnt_o}, 32'd0);
`endif

    // Reset two cycles into LOAD while a write is pending
    doReset();
    pulseStart();
    applyStimulus(32'hA5A5_0001, 1'b0, 0);
    applyStimulus(32'hA5A5_0002, 1'b0, 0);
    checkOutput("mid_we_pending", {31'd0, imem_we}, 32'd1);
    rst = 1'b1;
    stepCycle();
    checkOutput("mid_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("mid_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("mid_word_cnt", {29'd0, word_cnt_o}, 32'd0);
    checkOutput("mid_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("mid_imem_addr", imem_addr, 32'h0);
    rst = 1'b0;
    addr_q.delete();
    data_q.delete();
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("mid_no_writes", addr_q.size(), 32'd0);
    checkOutput("mid_idle_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("mid_idle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
